// File: rtl/fpga_config_loader.sv
// Streams 32-bit configuration words into shadow registers and commits a complete frame
// atomically to the LUT/switch-box buses. Optional feature macro: CFG_CHECKSUM_EN (trailing XOR word).
module fpga_config_loader #(
  parameter int N_LUT = 8,
  parameter int N_SB  = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [31:0]          cfg_data,
  output logic [N_LUT*33-1:0]  lut_cfg,
  output logic [N_SB*32-1:0]   sb_cfg,
  output logic                 fabric_en,
  output logic                 done,
  output logic                 error
);

  localparam int F  = N_LUT + N_SB + 1;
`ifdef CFG_CHECKSUM_EN
  localparam int FL = F + 1;
`else
  localparam int FL = F;
`endif
  // The final word of the frame is never stored; it is consumed on the commit edge.
  localparam int SD = FL - 1;
  localparam int CW = $clog2(FL + 1);
  localparam logic [31:0] RSV_MASK = 32'hFFFF_FFFF >> N_LUT;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERROR} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [31:0]         shadow [SD];
  logic [31:0]         w_word;
  logic                accept, last, frame_bad, commit_now, fail_now, restart;
  logic [N_LUT*33-1:0] lut_nxt;
  logic [N_SB*32-1:0]  sb_nxt;

  assign cfg_ready  = (state == LOAD);
  assign restart    = start && (state != COMMIT);
  assign accept     = cfg_ready && cfg_valid && !start;
  assign last       = (cnt == CW'(FL - 1));
  assign commit_now = accept && last && !frame_bad;
  assign fail_now   = accept && last && frame_bad;

`ifdef CFG_CHECKSUM_EN
  logic [31:0] xor_acc;
  assign w_word    = shadow[F-1];
  assign frame_bad = (|(w_word & RSV_MASK)) || (cfg_data != xor_acc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        xor_acc <= '0;
    else if (restart) xor_acc <= '0;
    else if (accept)  xor_acc <= xor_acc ^ cfg_data;
  end
`else
  assign w_word    = cfg_data;
  assign frame_bad = |(w_word & RSV_MASK);
`endif

  always_comb begin
    lut_nxt = '0;
    sb_nxt  = '0;
    for (int k = 0; k < N_LUT; k++) lut_nxt[33*k +: 33] = {w_word[31-k], shadow[k]};
    for (int k = 0; k < N_SB; k++)  sb_nxt[32*k +: 32]  = shadow[N_LUT+k];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (start)           state_nxt = LOAD;
        else if (commit_now) state_nxt = COMMIT;
        else if (fail_now)   state_nxt = ERROR;
      end
      COMMIT:  state_nxt = IDLE;
      ERROR:   if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SD; i++) shadow[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < SD; i++)
        if (cnt == CW'(i)) shadow[i] <= cfg_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      lut_cfg   <= '0;
      sb_cfg    <= '0;
      fabric_en <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= commit_now;
      if (restart) begin
        cnt       <= '0;
        fabric_en <= 1'b0;
        error     <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (commit_now) begin
        lut_cfg   <= lut_nxt;
        sb_cfg    <= sb_nxt;
        fabric_en <= 1'b1;
      end
      if (fail_now) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: stimulus pushes expected commit/error events,
// a negedge monitor pops and compares them when done or a new error appears.
module tb_fpga_config_loader;
  localparam int N_LUT = 8;
  localparam int N_SB  = 7;
  localparam int F     = N_LUT + N_SB + 1;
`ifdef CFG_CHECKSUM_EN
  localparam int FL = F + 1;
`else
  localparam int FL = F;
`endif

  logic                clock = 1'b0;
  logic                reset, start, cfg_valid;
  logic [31:0]         cfg_data;
  logic                cfg_ready;
  logic [N_LUT*33-1:0] lut_cfg;
  logic [N_SB*32-1:0]  sb_cfg;
  logic                fabric_en, done, error;

  fpga_config_loader #(.N_LUT(N_LUT), .N_SB(N_SB)) dut (
    .clock(clock), .reset(reset), .start(start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .lut_cfg(lut_cfg), .sb_cfg(sb_cfg),
    .fabric_en(fabric_en), .done(done), .error(error));

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0, n_dones = 0, exp_dones = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit                  is_err;
    logic [N_LUT*33-1:0] lut;
    logic [N_SB*32-1:0]  sb;
    int                  cyc;
  } exp_t;
  exp_t q[$];

  logic [N_LUT*33-1:0] last_lut = '0;
  logic [N_SB*32-1:0]  last_sb  = '0;
  logic [31:0]         lut_w [N_LUT];
  logic [31:0]         sb_w  [N_SB];
  logic [31:0]         w_word;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse and every new error must match the next queued event.
  logic error_q = 1'b0;
  always @(negedge clock) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      n_dones++;
      if (q.size() == 0) chk("unexpected_done", 300'(1), 300'(0));
      else begin
        e = q.pop_front();
        chk("done_kind_is_err", 300'(e.is_err), 300'(0));
        chk("lut_cfg", 300'(lut_cfg), 300'(e.lut));
        chk("sb_cfg", 300'(sb_cfg), 300'(e.sb));
        chk("fabric_en_on_done", 300'(fabric_en), 300'(1));
        chk("done_cycle", 300'(cyc), 300'(e.cyc));
      end
    end
    if (error === 1'b1 && error_q !== 1'b1) begin
      if (q.size() == 0) chk("unexpected_error", 300'(1), 300'(0));
      else begin
        e = q.pop_front();
        chk("error_kind_is_err", 300'(e.is_err), 300'(1));
        chk("lut_cfg_kept", 300'(lut_cfg), 300'(e.lut));
        chk("sb_cfg_kept", 300'(sb_cfg), 300'(e.sb));
        chk("fabric_en_on_error", 300'(fabric_en), 300'(0));
        chk("error_cycle", 300'(cyc), 300'(e.cyc));
      end
    end
    error_q = error;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // A junk word rides along with start; the loader must drop it.
  task automatic pulse_start(output int sc);
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hBAD0_BAD0;
    step();
    sc = cyc;
    start = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] w[$], input bit gap);
    foreach (w[i]) begin
      cfg_valid = 1'b1; cfg_data = w[i];
      step();
      if (gap) begin
        cfg_valid = 1'b0; cfg_data = 32'hDEAD_BEEF;
        step();
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk("scoreboard_drained", 300'(q.size()), 300'(0));
    q.delete();
  endtask

  task automatic frame_words(output logic [31:0] words[$], input bit bad_sum);
    logic [31:0] x;
    words = {};
    x = '0;
    for (int k = 0; k < N_LUT; k++) words.push_back(lut_w[k]);
    for (int k = 0; k < N_SB; k++)  words.push_back(sb_w[k]);
    words.push_back(w_word);
`ifdef CFG_CHECKSUM_EN
    foreach (words[i]) x ^= words[i];
    words.push_back(bad_sum ? (x ^ 32'h1) : x);
`else
    if (bad_sum) words[0] = words[0];
`endif
  endtask

  task automatic run_frame(input bit gap, input bit bad_sum);
    logic [31:0] words[$];
    exp_t e;
    int sc;
    frame_words(words, bad_sum);
    e.is_err = (|(w_word & (32'hFFFF_FFFF >> N_LUT)))
`ifdef CFG_CHECKSUM_EN
               || bad_sum
`endif
               ;
    for (int k = 0; k < N_LUT; k++) e.lut[33*k +: 33] = {w_word[31-k], lut_w[k]};
    for (int k = 0; k < N_SB; k++)  e.sb[32*k +: 32]  = sb_w[k];
    if (e.is_err) begin
      e.lut = last_lut;
      e.sb  = last_sb;
    end else begin
      last_lut = e.lut;
      last_sb  = e.sb;
      exp_dones++;
    end
    pulse_start(sc);
    e.cyc = sc + (gap ? 2*FL - 1 : FL);
    q.push_back(e);
    send_words(words, gap);
    wait_drain();
  endtask

  task automatic set_frame_a();
    for (int k = 0; k < N_LUT; k++) lut_w[k] = 32'h0000_0080 | (32'(k) << 20);
    for (int k = 0; k < N_SB; k++)  sb_w[k]  = 32'(k + 1) * 32'h1111_1111;
    w_word = 32'hFF00_0000;
  endtask

  task automatic set_frame_b();
    for (int k = 0; k < N_LUT; k++) lut_w[k] = ~(32'h0000_0080 | (32'(k) << 20));
    for (int k = 0; k < N_SB; k++)  sb_w[k]  = 32'(N_SB - k) * 32'h0101_0101;
    w_word = 32'h5A00_0000;
  endtask

  initial begin : global_timeout
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] words[$];
    logic [31:0] part[$];
    int sc;
    reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_lut_cfg", 300'(lut_cfg), 300'(0));
    chk("rst_sb_cfg", 300'(sb_cfg), 300'(0));
    chk("rst_fabric_en", 300'(fabric_en), 300'(0));
    chk("rst_done", 300'(done), 300'(0));
    chk("rst_error", 300'(error), 300'(0));
    chk("rst_cfg_ready", 300'(cfg_ready), 300'(0));

    // valid outside LOAD is ignored and ready stays low in IDLE
    cfg_valid = 1'b1; cfg_data = 32'h1234_5678;
    step();
    chk("idle_cfg_ready", 300'(cfg_ready), 300'(0));
    cfg_valid = 1'b0;

    set_frame_a();
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // abort after 5 words, then a full new frame
    set_frame_b();
    frame_words(words, 1'b0);
    part = words[0:4];
    pulse_start(sc);
    chk("load_cfg_ready", 300'(cfg_ready), 300'(1));
    chk("start_clears_fabric_en", 300'(fabric_en), 300'(0));
    send_words(part, 1'b0);
    run_frame(1'b0, 1'b0);

    // reserved bit set: error, image kept, next start clears error
    w_word = 32'hFF00_0001;
    run_frame(1'b0, 1'b0);
    chk("error_sticky", 300'(error), 300'(1));
    step();
    chk("error_state_ready", 300'(cfg_ready), 300'(0));
    pulse_start(sc);
    chk("start_clears_error", 300'(error), 300'(0));
    chk("fabric_en_after_err_start", 300'(fabric_en), 300'(0));

    // reset mid-frame at word 10
    set_frame_a();
    frame_words(words, 1'b0);
    part = words[0:9];
    pulse_start(sc);
    send_words(part, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_lut_cfg", 300'(lut_cfg), 300'(0));
    chk("midrst_sb_cfg", 300'(sb_cfg), 300'(0));
    chk("midrst_fabric_en", 300'(fabric_en), 300'(0));
    chk("midrst_error", 300'(error), 300'(0));
    chk("midrst_cfg_ready", 300'(cfg_ready), 300'(0));
    step();
    reset = 1'b0;
    last_lut = '0;
    last_sb  = '0;
    cfg_valid = 1'b1; cfg_data = 32'hCAFE_F00D;
    repeat (3) step();
    chk("postrst_cfg_ready", 300'(cfg_ready), 300'(0));
    cfg_valid = 1'b0;

    run_frame(1'b0, 1'b0);

`ifdef CFG_CHECKSUM_EN
    set_frame_b();
    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b1);
    chk("cksum_error", 300'(error), 300'(1));
`endif

    repeat (5) step();
    chk("done_count", 300'(n_dones), 300'(exp_dones));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
